// File: rtl/avalon_seg_display_ctrl_if.sv
// Avalon-MM slave bus bundle for the seven-segment display controller.
interface avalon_seg_display_ctrl_if;
  logic [3:0] avms_address_i;
  logic       avms_write_i;
  logic [7:0] avms_writedata_i;
  logic       avms_read_i;
  logic [7:0] avms_readdata_o;
  logic       avms_readdatavalid_o;

  modport slave (
    input  avms_address_i, avms_write_i, avms_writedata_i, avms_read_i,
    output avms_readdata_o, avms_readdatavalid_o
  );

  modport master (
    output avms_address_i, avms_write_i, avms_writedata_i, avms_read_i,
    input  avms_readdata_o, avms_readdatavalid_o
  );
endinterface

// File: rtl/avalon_seg_display_ctrl.sv
// Avalon-MM register block driving NUM_SEGMENT active-low seven-segment digits
// with hex/raw modes, per-digit enable and blink, and global PWM brightness.
module avalon_seg_display_ctrl #(
  parameter int unsigned NUM_SEGMENT       = 6,
  parameter int unsigned PWM_W             = 4,
  parameter int unsigned BLINK_HALF_PERIOD = 25_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  avalon_seg_display_ctrl_if.slave    avms,
  output logic [NUM_SEGMENT*7-1:0]    segment_symbol_o
);

  localparam int unsigned SEG_W   = NUM_SEGMENT * 7;
  localparam int unsigned BLINK_W = (BLINK_HALF_PERIOD > 2) ? $clog2(BLINK_HALF_PERIOD) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_PERIOD - 1);

  localparam logic [3:0] ADDR_ENABLE = 4'd8;
  localparam logic [3:0] ADDR_BLINK  = 4'd9;
  localparam logic [3:0] ADDR_RAW    = 4'd10;
  localparam logic [3:0] ADDR_BRIGHT = 4'd11;

  logic [6:0]             digit_q [NUM_SEGMENT];
  logic [6:0]             digit_d [NUM_SEGMENT];
  logic [NUM_SEGMENT-1:0] enable_q, enable_d;
  logic [NUM_SEGMENT-1:0] blink_q, blink_d;
  logic [NUM_SEGMENT-1:0] raw_q, raw_d;
  logic [PWM_W-1:0]       bright_q, bright_d;
  logic [PWM_W-1:0]       pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                   blink_phase_q, blink_phase_d;
  logic [7:0]             rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic [SEG_W-1:0]       seg_q, seg_d;

  logic [7:0] rdata_c;
  logic       pwm_on_c;
  logic       unused_ok;

  assign unused_ok = ^avms.avms_writedata_i;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Readback mux; unmapped addresses fall through to zero.
  always_comb begin
    rdata_c = 8'h00;
    for (int k = 0; k < NUM_SEGMENT; k++) begin
      if (avms.avms_address_i == 4'(k)) rdata_c = 8'(digit_q[k]);
    end
    case (avms.avms_address_i)
      ADDR_ENABLE: rdata_c = 8'(enable_q);
      ADDR_BLINK:  rdata_c = 8'(blink_q);
      ADDR_RAW:    rdata_c = 8'(raw_q);
      ADDR_BRIGHT: rdata_c = 8'(bright_q);
      default:     ;
    endcase
  end

  always_comb begin
    digit_d       = digit_q;
    enable_d      = enable_q;
    blink_d       = blink_q;
    raw_d         = raw_q;
    bright_d      = bright_q;
    pwm_cnt_d     = pwm_cnt_q + PWM_W'(1);
    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    rdata_d       = rdata_q;
    rvalid_d      = 1'b0;
    seg_d         = '1;
    pwm_on_c      = (bright_q == '1) || (pwm_cnt_q < bright_q);

    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

    if (avms.avms_write_i) begin
      for (int k = 0; k < NUM_SEGMENT; k++) begin
        if (avms.avms_address_i == 4'(k)) digit_d[k] = 7'(avms.avms_writedata_i);
      end
      case (avms.avms_address_i)
        ADDR_ENABLE: enable_d = NUM_SEGMENT'(avms.avms_writedata_i);
        ADDR_BLINK:  blink_d  = NUM_SEGMENT'(avms.avms_writedata_i);
        ADDR_RAW:    raw_d    = NUM_SEGMENT'(avms.avms_writedata_i);
        ADDR_BRIGHT: bright_d = PWM_W'(avms.avms_writedata_i);
        default:     ;
      endcase
    end else if (avms.avms_read_i) begin
      // A read colliding with a write is dropped so the write always wins.
      rvalid_d = 1'b1;
      rdata_d  = rdata_c;
    end

    for (int k = 0; k < NUM_SEGMENT; k++) begin
      if (enable_q[k] && pwm_on_c && !(blink_q[k] && blink_phase_q)) begin
        seg_d[7*k +: 7] = raw_q[k] ? digit_q[k] : hex_decode(digit_q[k][3:0]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q       <= '{default: '0};
      enable_q      <= '1;
      blink_q       <= '0;
      raw_q         <= '0;
      bright_q      <= '1;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      rdata_q       <= 8'h00;
      rvalid_q      <= 1'b0;
      seg_q         <= '1;
    end else begin
      digit_q       <= digit_d;
      enable_q      <= enable_d;
      blink_q       <= blink_d;
      raw_q         <= raw_d;
      bright_q      <= bright_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
      seg_q         <= seg_d;
    end
  end

  assign avms.avms_readdata_o      = rdata_q;
  assign avms.avms_readdatavalid_o = rvalid_q;
  assign segment_symbol_o          = seg_q;

endmodule

// File: tb/tb_avalon_seg_display_ctrl.sv
// Scoreboard bench for avalon_seg_display_ctrl: one 4-bit-PWM and one 2-bit-PWM
// instance share the same bus stimulus; read data is checked through a queue.
module tb_avalon_seg_display_ctrl;

  localparam int unsigned NSEG = 6;
  localparam int unsigned BHP  = 8;

  logic clk = 1'b0;
  logic rst;
  logic [NSEG*7-1:0] seg_a, seg_b;

  always #5 clk = ~clk;

  avalon_seg_display_ctrl_if bus_a ();
  avalon_seg_display_ctrl_if bus_b ();

  assign bus_b.avms_address_i   = bus_a.avms_address_i;
  assign bus_b.avms_write_i     = bus_a.avms_write_i;
  assign bus_b.avms_writedata_i = bus_a.avms_writedata_i;
  assign bus_b.avms_read_i      = bus_a.avms_read_i;

  avalon_seg_display_ctrl #(.NUM_SEGMENT(NSEG), .PWM_W(4), .BLINK_HALF_PERIOD(BHP)) dut_a (
    .clk(clk), .rst(rst), .avms(bus_a), .segment_symbol_o(seg_a)
  );

  avalon_seg_display_ctrl #(.NUM_SEGMENT(NSEG), .PWM_W(2), .BLINK_HALF_PERIOD(BHP)) dut_b (
    .clk(clk), .rst(rst), .avms(bus_b), .segment_symbol_o(seg_b)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic       exp_vld;
  logic [2:0] m_cnt;
  logic       m_phase, m_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dig(input logic [NSEG*7-1:0] s, input int k);
    return s[7*k +: 7];
  endfunction

  // Expected response strobe: one cycle after a read that did not collide with a write.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_vld <= 1'b0;
    else     exp_vld <= bus_a.avms_read_i && !bus_a.avms_write_i;
  end

  // Blink reference: phase toggles every BHP cycles, seen on the output one stage later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= '0; m_phase <= 1'b0; m_seen <= 1'b0;
    end else begin
      m_seen <= m_phase;
      if (m_cnt == 3'(BHP - 1)) begin
        m_cnt   <= '0;
        m_phase <= ~m_phase;
      end else begin
        m_cnt <= m_cnt + 3'd1;
      end
    end
  end

  always @(posedge rst) exp_q.delete();

  always @(negedge clk) begin
    if (!rst) begin
      check("rvalid", 32'(bus_a.avms_readdatavalid_o), 32'(exp_vld));
      if (bus_a.avms_readdatavalid_o) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
        else                   check("rdata", 32'(bus_a.avms_readdata_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic bus_cycle(input bit rd, input bit wr, input logic [3:0] addr,
                           input logic [7:0] data, input logic [7:0] exp);
    @(negedge clk);
    bus_a.avms_read_i      = rd;
    bus_a.avms_write_i     = wr;
    bus_a.avms_address_i   = addr;
    bus_a.avms_writedata_i = data;
    if (rd && !wr) exp_q.push_back(exp);
  endtask

  task automatic bus_idle();
    @(negedge clk);
    bus_a.avms_read_i  = 1'b0;
    bus_a.avms_write_i = 1'b0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] data);
    bus_cycle(1'b0, 1'b1, addr, data, 8'h00);
    bus_idle();
  endtask

  task automatic rd(input logic [3:0] addr, input logic [7:0] exp);
    bus_cycle(1'b1, 1'b0, addr, 8'h00, exp);
    bus_idle();
  endtask

  task automatic count_lit(input bit use_b, input int cycles, output int lit);
    logic [6:0] d;
    lit = 0;
    repeat (cycles) begin
      @(negedge clk);
      d = use_b ? dig(seg_b, 1) : dig(seg_a, 1);
      if (d == 7'h03) lit++;
      else check("pwm_dark", 32'(d), 32'h7F);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rst_tab [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                 8'h00, 8'h00, 8'h3F, 8'h00, 8'h00, 8'h0F};
    logic [7:0] hex_val [6]  = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
    logic [6:0] hex_exp [6]  = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int lit;

    rst = 1'b1;
    bus_a.avms_read_i      = 1'b0;
    bus_a.avms_write_i     = 1'b0;
    bus_a.avms_address_i   = 4'h0;
    bus_a.avms_writedata_i = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg_a), 32'hFFFF_FFFF);
    check("rst_seg_hi", 32'(seg_a[NSEG*7-1:32]), 32'h3FF);
    check("rst_rvalid", 32'(bus_a.avms_readdatavalid_o), 32'd0);
    check("rst_rdata", 32'(bus_a.avms_readdata_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NSEG; k++) check("rst_digit", 32'(dig(seg_a, k)), 32'h40);

    // Back-to-back readback of the whole map.
    for (int a = 0; a < 12; a++) bus_cycle(1'b1, 1'b0, 4'(a), 8'h00, rst_tab[a]);
    bus_idle();
    @(negedge clk);

    for (int k = 0; k < NSEG; k++) begin
      wr(4'(k), hex_val[k]);
      check("hex_early", 32'(dig(seg_a, k)), 32'h40);
      @(negedge clk);
      check("hex", 32'(dig(seg_a, k)), 32'(hex_exp[k]));
    end
    rd(4'd2, 8'h0C);

    wr(4'd10, 8'h01);
    wr(4'd0, 8'h36);
    @(negedge clk);
    check("raw_d0", 32'(dig(seg_a, 0)), 32'h36);
    rd(4'd0, 8'h36);
    wr(4'd8, 8'hFE);
    @(negedge clk);
    check("en_d0", 32'(dig(seg_a, 0)), 32'h7F);
    check("en_d1", 32'(dig(seg_a, 1)), 32'h03);
    rd(4'd8, 8'h3E);

    wr(4'd9, 8'h04);
    repeat (2) @(negedge clk);
    repeat (40) begin
      @(negedge clk);
      check("blink_d2", 32'(dig(seg_a, 2)), m_seen ? 32'h7F : 32'h46);
      check("blink_d1", 32'(dig(seg_a, 1)), 32'h03);
    end
    wr(4'd9, 8'h00);

    wr(4'd11, 8'h01);
    repeat (2) @(negedge clk);
    count_lit(1'b1, 16, lit);
    check("pwm_b_bright1", 32'(lit), 32'd4);
    count_lit(1'b0, 32, lit);
    check("pwm_a_bright1", 32'(lit), 32'd2);
    wr(4'd11, 8'h03);
    repeat (2) @(negedge clk);
    count_lit(1'b1, 16, lit);
    check("pwm_b_bright3", 32'(lit), 32'd16);
    wr(4'd11, 8'h00);
    repeat (2) @(negedge clk);
    count_lit(1'b1, 16, lit);
    check("pwm_b_bright0", 32'(lit), 32'd0);
    wr(4'd11, 8'h0F);

    wr(4'd13, 8'hAA);
    wr(4'd6, 8'h55);
    rd(4'd13, 8'h00);
    rd(4'd12, 8'h00);
    rd(4'd6, 8'h00);
    rd(4'd7, 8'h00);

    // Collision: the write lands, no response is produced.
    bus_cycle(1'b1, 1'b1, 4'd11, 8'h05, 8'h00);
    bus_idle();
    @(negedge clk);
    rd(4'd11, 8'h05);

    // Reset between a read strobe and its response.
    @(negedge clk);
    bus_a.avms_read_i    = 1'b1;
    bus_a.avms_address_i = 4'd11;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rvalid", 32'(bus_a.avms_readdatavalid_o), 32'd0);
    check("mid_rst_rdata", 32'(bus_a.avms_readdata_o), 32'd0);
    check("mid_rst_seg", 32'(seg_a), 32'hFFFF_FFFF);
    @(negedge clk);
    bus_a.avms_read_i = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("mid_rst_rvalid_hold", 32'(bus_a.avms_readdatavalid_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_d0", 32'(dig(seg_a, 0)), 32'h40);
    rd(4'd11, 8'h0F);
    rd(4'd8, 8'h3F);
    rd(4'd0, 8'h00);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
